// File: rtl/nios2_cpu_debug_ocimem.sv
// Debug-side on-chip memory for the Nios II JTAG monitor: executes monitor read/write
// commands against a private debug RAM and shares that RAM with a lower-priority CPU port.
module nios2_cpu_debug_ocimem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid
);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAP, WR} state_e;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mona_q, mona_d;
    logic [31:0]       mond_q, mond_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              rd_inc_q, rd_inc_d;
    logic              a_done_q, a_done_d;
    logic [ADDR_W-1:0] raddr_q;
    logic              cpu_rd_pend_q, cpu_rd_ok_q;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rvalid_q;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q, ram_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    logic idle, acc_a, acc_na, acc_b, acc_any, drop, mon_ok, done;
    logic cpu_acc, cpu_wr_acc, cpu_rd_acc;

    // jdo bits outside the data/address/read-flag fields carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Command acceptance: only in IDLE, ocimem_b > ocimem_a > no_action_a
    assign idle    = (state_q == IDLE);
    assign acc_b   = idle & take_action_ocimem_b;
    assign acc_a   = idle & take_action_ocimem_a & ~take_action_ocimem_b;
    assign acc_na  = idle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign acc_any = acc_a | acc_na | acc_b;
    assign drop    = (take_action_ocimem_a & ~acc_a) | (take_no_action_ocimem_a & ~acc_na)
                   | (take_action_ocimem_b & ~acc_b);
    assign mon_ok  = in_range(mona_q);
    assign done    = (state_q == RD_CAP) | (state_q == WR);

    assign cpu_waitrequest = ~idle | take_action_ocimem_a | take_no_action_ocimem_a
                           | take_action_ocimem_b;
    assign cpu_acc    = (cpu_read | cpu_write) & ~cpu_waitrequest;
    assign cpu_wr_acc = cpu_acc & cpu_write;
    assign cpu_rd_acc = cpu_acc & ~cpu_write;

    // Single RAM port: the monitor owns it whenever the FSM is busy
    assign ram_addr  = idle ? cpu_address : mona_q;
    assign ram_wdata = idle ? cpu_writedata : mond_q;
    assign ram_we    = ((state_q == WR) & mon_ok) | (cpu_wr_acc & in_range(cpu_address));
    assign ram_q     = mem[raddr_q];

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mona_q        <= '0;
            mond_q        <= '0;
            ready_q       <= 1'b0;
            error_q       <= 1'b0;
            rd_inc_q      <= 1'b0;
            a_done_q      <= 1'b0;
            raddr_q       <= '0;
            cpu_rd_pend_q <= 1'b0;
            cpu_rd_ok_q   <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mona_q        <= mona_d;
            mond_q        <= mond_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
            rd_inc_q      <= rd_inc_d;
            a_done_q      <= a_done_d;
            raddr_q       <= ram_addr;
            cpu_rd_pend_q <= cpu_rd_acc;
            cpu_rd_ok_q   <= in_range(cpu_address);
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_rvalid_q  <= cpu_rd_pend_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_b)                    state_d = WR;
                else if (acc_a && jdo[35])    state_d = RD_ADDR;
                else if (acc_na)              state_d = RD_ADDR;
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mona_d   = mona_q;
        mond_d   = mond_q;
        ready_d  = ready_q;
        rd_inc_d = rd_inc_q;
        a_done_d = 1'b0;
        if (acc_a) begin
            mona_d   = jdo[17 +: ADDR_W];
            a_done_d = ~jdo[35];
            rd_inc_d = 1'b0;
        end
        if (acc_na) rd_inc_d = 1'b1;
        if (acc_b)  mond_d = jdo[34:3];
        case (state_q)
            RD_CAP: begin
                if (mon_ok)   mond_d = ram_q;
                if (rd_inc_q) mona_d = mona_q + 1'b1;
                ready_d = 1'b1;
            end
            WR: begin
                mona_d  = mona_q + 1'b1;
                ready_d = 1'b1;
            end
            default: ;
        endcase
        if (a_done_q) ready_d = 1'b1;
        // A newly accepted command always wins over a completion landing on the same edge
        if (acc_any) ready_d = 1'b0;
        error_d = (acc_a ? 1'b0 : error_q) | drop | (done & ~mon_ok);
    end

    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        if (cpu_rd_pend_q) cpu_rdata_d = cpu_rd_ok_q ? ram_q : 32'h0;
    end

    assign MonDReg           = mond_q;
    assign monitor_ready     = ready_q;
    assign monitor_error     = error_q;
    assign cpu_readdata      = cpu_rdata_q;
    assign cpu_readdatavalid = cpu_rvalid_q;

endmodule

// File: tb/tb_nios2_cpu_debug_ocimem.sv
// Directed bench for nios2_cpu_debug_ocimem: a full-depth instance plus a DEPTH=200
// instance sharing the same stimulus to exercise out-of-range handling.
module tb_nios2_cpu_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;

    logic [31:0] mond, mond2, rdata, rdata2;
    logic        rdy, rdy2, err, err2, wait1, wait2, rv, rv2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_cpu_debug_ocimem #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
        .MonDReg(mond), .monitor_ready(rdy), .monitor_error(err),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_waitrequest(wait1),
        .cpu_readdata(rdata), .cpu_readdatavalid(rv)
    );

    nios2_cpu_debug_ocimem #(.ADDR_W(8), .DEPTH(200)) dut2 (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
        .MonDReg(mond2), .monitor_ready(rdy2), .monitor_error(err2),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_waitrequest(wait2),
        .cpu_readdata(rdata2), .cpu_readdatavalid(rv2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd);
        jdo = '0;
        jdo[35] = rd;
        jdo[24:17] = addr;
        ta_a = 1'b1;
        tick();
        ta_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        ta_b = 1'b1;
        tick();
        ta_b = 1'b0;
    endtask

    task automatic pulse_na();
        tna_a = 1'b1;
        tick();
        tna_a = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data);
        cpu_address = addr;
        cpu_writedata = data;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
        cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
        repeat (3) tick();
        checks++; if (mond !== 32'h0) begin errors++; $display("FAIL reset_mondreg: got %h exp 0", mond); end
        checks++; if ({rdy, err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got rdy=%b err=%b exp 0/0", rdy, err); end
        checks++; if ({rdata, rv} !== 33'h0) begin errors++; $display("FAIL reset_cpu: got data=%h valid=%b exp 0/0", rdata, rv); end
        checks++; if (wait1 !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b exp 0", wait1); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        pulse_a(8'h10, 1'b0);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL wr_a_accept_ready: got %b exp 0", rdy); end
        tick();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_a_done_ready: got %b exp 1", rdy); end
        pulse_b(32'hDEADBEEF);
        checks++; if (mond !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_b_mondreg: got %h exp deadbeef", mond); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL wr_b_accept_ready: got %b exp 0", rdy); end
        tick();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_b_done_ready: got %b exp 1", rdy); end
        pulse_a(8'h10, 1'b1);
        tick();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rd_e1_ready: got %b exp 0", rdy); end
        tick();
        checks++; if ({mond, rdy, err} !== {32'hDEADBEEF, 2'b10}) begin errors++;
            $display("FAIL rd_e2: got %h rdy=%b err=%b exp deadbeef/1/0", mond, rdy, err); end
    endtask

    task automatic test_cpu_read();
        cpu_address = 8'h10;
        cpu_read = 1'b1;
        #1;
        checks++; if (wait1 !== 1'b0) begin errors++; $display("FAIL cpu_rd_wait: got %b exp 0", wait1); end
        tick();
        cpu_read = 1'b0;
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL cpu_rd_early_valid: got %b exp 0", rv); end
        tick();
        checks++; if ({rv, rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++;
            $display("FAIL cpu_rd_data: got valid=%b %h exp 1/deadbeef", rv, rdata); end
        tick();
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL cpu_rd_valid_pulse: got %b exp 0", rv); end
        cpu_address = 8'd250;
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        tick();
        checks++; if ({rv2, rdata2} !== {1'b1, 32'h0}) begin errors++;
            $display("FAIL cpu_rd_oor: got valid=%b %h exp 1/00000000", rv2, rdata2); end
        tick();
    endtask

    task automatic test_stream_wrap();
        cpu_wr(8'hFF, 32'hA5A5A5A5);
        cpu_wr(8'h00, 32'h12345678);
        cpu_wr(8'h01, 32'h0BADF00D);
        pulse_a(8'hFF, 1'b0);
        tick();
        pulse_na();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL stream_accept_ready: got %b exp 0", rdy); end
        tick(); tick();
        checks++; if ({mond, rdy} !== {32'hA5A5A5A5, 1'b1}) begin errors++;
            $display("FAIL stream_rd0: got %h rdy=%b exp a5a5a5a5/1", mond, rdy); end
        pulse_na(); tick(); tick();
        checks++; if (mond !== 32'h12345678) begin errors++; $display("FAIL stream_rd_wrap: got %h exp 12345678", mond); end
        pulse_na(); tick(); tick();
        checks++; if ({mond, err} !== {32'h0BADF00D, 1'b0}) begin errors++;
            $display("FAIL stream_rd_addr1: got %h err=%b exp 0badf00d/0", mond, err); end
    endtask

    task automatic test_busy_drop();
        pulse_b(32'h11111111);
        tna_a = 1'b1;
        tick();
        tna_a = 1'b0;
        checks++; if ({err, rdy} !== 2'b11) begin errors++; $display("FAIL busy_drop_err: got err=%b rdy=%b exp 1/1", err, rdy); end
        tick();
        checks++; if ({err, rdy} !== 2'b11) begin errors++; $display("FAIL busy_drop_ignored: got err=%b rdy=%b exp 1/1", err, rdy); end
        pulse_a(8'h00, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL busy_err_clear: got %b exp 0", err); end
        tick();
    endtask

    task automatic test_priority();
        jdo = '0;
        jdo[34:3] = 32'h22222222;
        ta_a = 1'b1;
        ta_b = 1'b1;
        tick();
        ta_a = 1'b0;
        ta_b = 1'b0;
        checks++; if (mond !== 32'h22222222) begin errors++; $display("FAIL prio_b_wins: got %h exp 22222222", mond); end
        tick();
        checks++; if ({err, rdy} !== 2'b11) begin errors++; $display("FAIL prio_loser_err: got err=%b rdy=%b exp 1/1", err, rdy); end
    endtask

    task automatic test_out_of_range();
        pulse_a(8'd200, 1'b1);
        checks++; if ({err2, rdy2} !== 2'b00) begin errors++; $display("FAIL oor_accept: got err=%b rdy=%b exp 0/0", err2, rdy2); end
        tick(); tick();
        checks++; if ({mond2, err2, rdy2} !== {32'h22222222, 2'b11}) begin errors++;
            $display("FAIL oor_complete: got %h err=%b rdy=%b exp 22222222/1/1", mond2, err2, rdy2); end
        checks++; if ({err, rdy} !== 2'b01) begin errors++; $display("FAIL oor_full_depth_ok: got err=%b rdy=%b exp 0/1", err, rdy); end
    endtask

    task automatic test_arbitration();
        pulse_a(8'h05, 1'b0);
        tick();
        jdo = '0;
        jdo[34:3] = 32'hCAFEF00D;
        ta_b = 1'b1;
        cpu_address = 8'h05;
        cpu_read = 1'b1;
        #1;
        checks++; if (wait1 !== 1'b1) begin errors++; $display("FAIL arb_wait_c0: got %b exp 1", wait1); end
        tick();
        ta_b = 1'b0;
        checks++; if (wait1 !== 1'b1) begin errors++; $display("FAIL arb_wait_c1: got %b exp 1", wait1); end
        tick();
        checks++; if (wait1 !== 1'b0) begin errors++; $display("FAIL arb_wait_c2: got %b exp 0", wait1); end
        tick();
        cpu_read = 1'b0;
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL arb_early_valid: got %b exp 0", rv); end
        tick();
        checks++; if ({rv, rdata} !== {1'b1, 32'hCAFEF00D}) begin errors++;
            $display("FAIL arb_rdata: got valid=%b %h exp 1/cafef00d", rv, rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        pulse_na();
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({mond, rdy, err} !== 34'h0) begin errors++;
            $display("FAIL rst_async_mon: got %h rdy=%b err=%b exp 0/0/0", mond, rdy, err); end
        checks++; if ({rdata, rv} !== 33'h0) begin errors++; $display("FAIL rst_async_cpu: got %h valid=%b exp 0/0", rdata, rv); end
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_no_ready_%0d: got %b exp 0", i, rdy); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_cpu_read();
        test_stream_wrap();
        test_busy_drop();
        test_priority();
        test_out_of_range();
        test_arbitration();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
